// File: rtl/ctrl_pkg.sv
// Shared encodings for the RV32I control units: FSM states, opcodes
// and the datapath select codes driven by the controllers.
package ctrl_pkg;

   localparam logic [3:0] S_FETCH    = 4'd0;
   localparam logic [3:0] S_DECODE   = 4'd1;
   localparam logic [3:0] S_MEMADR   = 4'd2;
   localparam logic [3:0] S_MEMREAD  = 4'd3;
   localparam logic [3:0] S_MEMWB    = 4'd4;
   localparam logic [3:0] S_MEMWRITE = 4'd5;
   localparam logic [3:0] S_EXECR    = 4'd6;
   localparam logic [3:0] S_EXECI    = 4'd7;
   localparam logic [3:0] S_ALUWB    = 4'd8;
   localparam logic [3:0] S_BEQ      = 4'd9;
   localparam logic [3:0] S_JAL      = 4'd10;
   localparam logic [3:0] S_TRAP     = 4'd11;

   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_IALU = 7'b0010011;
   localparam logic [6:0] OP_BEQ  = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_MEM    = 2'b01;
   localparam logic [1:0] RES_ALU    = 2'b10;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/imm_sel_dec.sv
// Opcode to immediate-format decoder, shared by the single-cycle
// and multicycle controllers.
module imm_sel_dec
   import ctrl_pkg::*;
(
   input  logic [6:0] op_code,
   output logic [1:0] imm_src
);

   always_comb begin
      imm_src = IMM_I;
      unique case (1'b1)
         (op_code == OP_SW):  imm_src = IMM_S;
         (op_code == OP_BEQ): imm_src = IMM_B;
         (op_code == OP_JAL): imm_src = IMM_J;
         default:             imm_src = IMM_I;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle RV32I main controller with retired-instruction counter.
// Define CTRL_ILLEGAL_TRAP_EN to trap on unknown opcodes.
module multicycle_ctrl_fsm
   import ctrl_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [6:0]       op_code,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             pc_write,
   output logic             adr_src,
   output logic             mem_write,
   output logic             ir_write,
   output logic [1:0]       result_src,
   output logic [1:0]       alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       alu_op,
   output logic [1:0]       imm_src,
   output logic             reg_write,
`ifdef CTRL_ILLEGAL_TRAP_EN
   output logic             illegal,
`endif
   output logic [CNT_W-1:0] retire_cnt
);

   logic [3:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       st;
   logic             retire;

   imm_sel_dec u_imm_sel_dec (
      .op_code (op_code),
      .imm_src (imm_src)
   );

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_FETCH:    if (mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            unique case (1'b1)
               (op_code == OP_LW),
               (op_code == OP_SW):   state_d = S_MEMADR;
               (op_code == OP_R):    state_d = S_EXECR;
               (op_code == OP_IALU): state_d = S_EXECI;
               (op_code == OP_BEQ):  state_d = S_BEQ;
               (op_code == OP_JAL):  state_d = S_JAL;
`ifdef CTRL_ILLEGAL_TRAP_EN
               default:              state_d = S_TRAP;
`else
               default:              state_d = S_FETCH;
`endif
            endcase
         end
         S_MEMADR:   state_d = (op_code == OP_LW) ? S_MEMREAD
                                                  : S_MEMWRITE;
         S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
         S_MEMWB:    state_d = S_FETCH;
         S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
         S_EXECR:    state_d = S_ALUWB;
         S_EXECI:    state_d = S_ALUWB;
         S_ALUWB:    state_d = S_FETCH;
         S_BEQ:      state_d = S_FETCH;
         S_JAL:      state_d = S_ALUWB;
         S_TRAP:     state_d = S_TRAP;
         default:    state_d = S_FETCH;
      endcase
   end

   // Only the final step of a completed instruction retires it.
   always_comb begin
      retire = 1'b0;
      unique case (state_q)
         S_MEMWB, S_ALUWB, S_BEQ: retire = 1'b1;
         S_MEMWRITE:              retire = mem_ready;
         default:                 retire = 1'b0;
      endcase
      cnt_d = retire ? cnt_q + CNT_W'(1) : cnt_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_FETCH;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign retire_cnt = cnt_q;

   // Reset forces FETCH decode so a pending store drops immediately.
   always_comb begin
      st         = reset ? S_FETCH : state_q;
      pc_write   = 1'b0;
      adr_src    = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      result_src = RES_ALUOUT;
      alu_src_a  = SRCA_PC;
      alu_src_b  = SRCB_RS2;
      alu_op     = ALUOP_ADD;
      reg_write  = 1'b0;
      unique case (st)
         S_FETCH: begin
            alu_src_b  = SRCB_FOUR;
            result_src = RES_ALU;
            ir_write   = mem_ready;
            pc_write   = mem_ready;
         end
         S_DECODE: begin
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_IMM;
         end
         S_MEMADR: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_IMM;
         end
         S_MEMREAD:  adr_src = 1'b1;
         S_MEMWB: begin
            result_src = RES_MEM;
            reg_write  = 1'b1;
         end
         S_MEMWRITE: begin
            adr_src   = 1'b1;
            mem_write = 1'b1;
         end
         S_EXECR: begin
            alu_src_a = SRCA_RS1;
            alu_op    = ALUOP_FUNCT;
         end
         S_EXECI: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_IMM;
            alu_op    = ALUOP_FUNCT;
         end
         S_ALUWB:    reg_write = 1'b1;
         S_BEQ: begin
            alu_src_a = SRCA_RS1;
            alu_op    = ALUOP_SUB;
            pc_write  = zero;
         end
         S_JAL: begin
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_FOUR;
            pc_write  = 1'b1;
         end
         default: ;
      endcase
   end

`ifdef CTRL_ILLEGAL_TRAP_EN
   assign illegal = (st == S_TRAP);
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Randomized check of the multicycle controller against a per-
// instruction step-sequence model with a 4-bit retire counter.
module tb_multicycle_ctrl_fsm;

   localparam int W = 4;

   typedef enum int {
      P_F, P_D, P_MA, P_MR, P_MWB, P_MW,
      P_XR, P_XI, P_AWB, P_BEQ, P_JAL, P_TRAP
   } ph_t;

   logic         clk = 1'b0;
   logic         reset;
   logic [6:0]   op_code;
   logic         zero;
   logic         mem_ready;
   logic         pc_write, adr_src, mem_write, ir_write;
   logic [1:0]   result_src, alu_src_a, alu_src_b, alu_op, imm_src;
   logic         reg_write;
   logic [W-1:0] retire_cnt;
`ifdef CTRL_ILLEGAL_TRAP_EN
   logic         illegal;
`endif

   int n_chk  = 0;
   int n_pass = 0;
   int exp_cnt = 0;

   always #5 clk = ~clk;

   multicycle_ctrl_fsm #(.CNT_W(W)) dut (
      .clk        (clk),
      .reset      (reset),
      .op_code    (op_code),
      .zero       (zero),
      .mem_ready  (mem_ready),
      .pc_write   (pc_write),
      .adr_src    (adr_src),
      .mem_write  (mem_write),
      .ir_write   (ir_write),
      .result_src (result_src),
      .alu_src_a  (alu_src_a),
      .alu_src_b  (alu_src_b),
      .alu_op     (alu_op),
      .imm_src    (imm_src),
      .reg_write  (reg_write),
`ifdef CTRL_ILLEGAL_TRAP_EN
      .illegal    (illegal),
`endif
      .retire_cnt (retire_cnt)
   );

   logic [14:0] obs;
   assign obs = {pc_write, adr_src, mem_write, ir_write, result_src,
                 alu_src_a, alu_src_b, alu_op, imm_src, reg_write};

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp,
                    $time);
   endtask

   function automatic logic [14:0] ctl_exp(ph_t p, logic mr, logic z,
                                           logic [6:0] op);
      logic       pw, as, mw, iw, rw;
      logic [1:0] rs, a, b, ao, im;
      pw = 0; as = 0; mw = 0; iw = 0; rw = 0;
      rs = 0; a = 0; b = 0; ao = 0;
      case (op)
         7'b0100011: im = 2'b01;
         7'b1100011: im = 2'b10;
         7'b1101111: im = 2'b11;
         default:    im = 2'b00;
      endcase
      case (p)
         P_F:   begin b = 2; rs = 2; iw = mr; pw = mr; end
         P_D:   begin a = 1; b = 1; end
         P_MA:  begin a = 2; b = 1; end
         P_MR:  as = 1;
         P_MWB: begin rs = 1; rw = 1; end
         P_MW:  begin as = 1; mw = 1; end
         P_XR:  begin a = 2; ao = 2; end
         P_XI:  begin a = 2; b = 1; ao = 2; end
         P_AWB: rw = 1;
         P_BEQ: begin a = 2; ao = 1; pw = z; end
         P_JAL: begin a = 1; b = 2; pw = 1; end
         default: ;
      endcase
      return {pw, as, mw, iw, rs, a, b, ao, im, rw};
   endfunction

   function automatic int lat_exp(logic [6:0] op);
      case (op)
         7'b1100011: return 3;
         7'b0000011: return 5;
         7'b0100011, 7'b0110011,
         7'b0010011, 7'b1101111: return 4;
         default:    return 2;
      endcase
   endfunction

   task automatic cycle_check(ph_t p, logic [6:0] op);
      check("ctl", {17'd0, obs}, {17'd0, ctl_exp(p, mem_ready, zero, op)});
      check("cnt", {28'd0, retire_cnt}, exp_cnt);
`ifdef CTRL_ILLEGAL_TRAP_EN
      check("illegal", {31'd0, illegal}, {31'd0, p == P_TRAP});
`endif
   endtask

   // fixed_stall > 0 forces that many low mem_ready cycles in the
   // memory-access step, otherwise stalls come from stall_pct.
   task automatic run_instr(input logic [6:0] op, input logic z,
                            input int stall_pct, input int fixed_stall);
      ph_t q[$];
      int  idx, cyc, stalls, mstall;
      logic counted;
      q = {P_F, P_D};
      counted = 1;
      case (op)
         7'b0000011: q = {q, P_MA, P_MR, P_MWB};
         7'b0100011: q = {q, P_MA, P_MW};
         7'b0110011: q = {q, P_XR, P_AWB};
         7'b0010011: q = {q, P_XI, P_AWB};
         7'b1100011: q.push_back(P_BEQ);
         7'b1101111: q = {q, P_JAL, P_AWB};
         default: begin
            counted = 0;
`ifdef CTRL_ILLEGAL_TRAP_EN
            q.push_back(P_TRAP);
`endif
         end
      endcase
      idx = 0; cyc = 0; stalls = 0; mstall = 0;
      while (idx < q.size() && cyc < 300) begin
         @(negedge clk);
         op_code = op;
         zero    = z;
         if (q[idx] inside {P_F, P_MR, P_MW}) begin
            if (fixed_stall > 0 && q[idx] != P_F)
               mem_ready = (mstall >= fixed_stall);
            else if (fixed_stall > 0)
               mem_ready = 1'b1;
            else
               mem_ready = ($urandom_range(99) >= stall_pct);
         end else begin
            mem_ready = 1'($urandom);
         end
         #1;
         cycle_check(q[idx], op);
         cyc++;
         if (q[idx] == P_TRAP) begin
            idx++;
         end else if (!(q[idx] inside {P_F, P_MR, P_MW}) || mem_ready) begin
            idx++;
            if (idx == q.size() && counted)
               exp_cnt = (exp_cnt + 1) % (1 << W);
         end else begin
            stalls++;
            if (q[idx] != P_F) mstall++;
         end
      end
      if (cyc >= 300) check("timeout", 32'd1, 32'd0);
      if (q[q.size()-1] != P_TRAP)
         check("lat", cyc, lat_exp(op) + stalls);
   endtask

   logic [6:0] ops [7];

   initial begin
      ops[0] = 7'b0000011; ops[1] = 7'b0100011; ops[2] = 7'b0110011;
      ops[3] = 7'b0010011; ops[4] = 7'b1100011; ops[5] = 7'b1101111;
      ops[6] = 7'b0000000;
      reset = 1; op_code = 0; zero = 0; mem_ready = 0;
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      cycle_check(P_F, 7'b0000000);
      @(negedge clk);
      reset = 0;

      run_instr(7'b0000011, 1'b0, 0, 0);
      run_instr(7'b0100011, 1'b0, 0, 3);
      run_instr(7'b1100011, 1'b1, 0, 0);
      run_instr(7'b1100011, 1'b0, 0, 0);
      run_instr(7'b1101111, 1'b0, 0, 0);
`ifndef CTRL_ILLEGAL_TRAP_EN
      run_instr(7'b0000000, 1'b0, 0, 0);
`endif
      for (int i = 0; i < 16; i++) run_instr(7'b0110011, 1'b0, 0, 0);
      for (int i = 0; i < 150; i++) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
         run_instr(ops[$urandom_range(5)], 1'($urandom), 25, 0);
`else
         run_instr(ops[$urandom_range(6)], 1'($urandom), 25, 0);
`endif
      end

      // reset in the middle of a stalled store
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         op_code = 7'b0100011; mem_ready = 1;
      end
      @(negedge clk);
      mem_ready = 0; #1;
      check("mw_hold", {31'd0, mem_write}, 32'd1);
      reset = 1; #1;
      check("mw_drop", {31'd0, mem_write}, 32'd0);
      exp_cnt = 0;
      @(negedge clk);
      reset = 0; mem_ready = 0; #1;
      cycle_check(P_F, 7'b0100011);

`ifdef CTRL_ILLEGAL_TRAP_EN
      run_instr(7'b0000000, 1'b0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         mem_ready = 1'($urandom); #1;
         cycle_check(P_TRAP, 7'b0000000);
      end
      @(negedge clk);
      reset = 1;
      @(negedge clk);
      reset = 0; mem_ready = 0; #1;
      exp_cnt = 0;
      cycle_check(P_F, 7'b0000000);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
Main control state machine for the multicycle variant of the RV32I core. It sequences the shared datapath (PC, unified memory port, IR, register file, ALU, immediate generator) across cycles for lw, sw, R-type, I-type ALU, beq and jal. It drives all datapath select and enable signals and the immediate-format select. It also counts retired instructions.

Parameters:
CNT_W, 32, width of the retired-instruction counter

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
op_code  input  7  opcode field from the held IR (instruction[6:0])
zero  input  1  ALU zero flag
mem_ready  input  1  memory completes the current access this cycle
pc_write  output  1  PC load enable
adr_src  output  1  memory address select: 0 = PC, 1 = ALU result register
mem_write  output  1  memory write request
ir_write  output  1  IR and old-PC load enable
result_src  output  2  result select: 00 = ALUOut, 01 = memory data, 10 = ALU result
alu_src_a  output  2  ALU A select: 00 = PC, 01 = old PC, 10 = rs1
alu_src_b  output  2  ALU B select: 00 = rs2, 01 = ImmExt, 10 = constant 4
alu_op  output  2  ALU decoder class: 00 = add, 01 = sub, 10 = funct-decoded
imm_src  output  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J
reg_write  output  1  register-file write enable
retire_cnt  output  CNT_W  retired-instruction count

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous, active-high, named reset, and overrides all other inputs.
- Reset state:
  - State goes to FETCH and retire_cnt goes to 0.
  - All outputs are Moore-decoded from state, except the mem_ready/zero gating noted below. With reset high, outputs show FETCH values: adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10, mem_write=0, reg_write=0.
- Unlisted outputs in any state are 0.
- imm_src is combinational from op_code in every state:
  - lw or I-ALU → 00
  - sw → 01
  - beq → 10
  - jal → 11
  - any other opcode → 00
- Opcodes: lw 0000011, sw 0100011, R 0110011, I-ALU 0010011, beq 1100011, jal 1101111.
- States and transitions:
  - FETCH:
    - Outputs: adr_src=0, a=00, b=10, alu_op=00, result_src=10, ir_write=mem_ready, pc_write=mem_ready.
    - Next: DECODE if mem_ready, else stay in FETCH.
  - DECODE:
    - Outputs: a=01, b=01, alu_op=00 (branch/jump target computed into ALUOut).
    - Next by opcode: lw/sw → MEMADR, R → EXECR, I-ALU → EXECI, beq → BEQ, jal → JAL, other → FETCH (instruction skipped, not counted).
  - MEMADR:
    - Outputs: a=10, b=01, alu_op=00.
    - Next: lw → MEMREAD, else → MEMWRITE.
  - MEMREAD:
    - Outputs: adr_src=1.
    - Next: MEMWB if mem_ready, else stay.
  - MEMWB:
    - Outputs: result_src=01, reg_write=1.
    - Next: FETCH.
  - MEMWRITE:
    - Outputs: adr_src=1, mem_write=1, held constant until mem_ready.
    - Next: FETCH when mem_ready.
  - EXECR:
    - Outputs: a=10, b=00, alu_op=10.
    - Next: ALUWB.
  - EXECI:
    - Outputs: a=10, b=01, alu_op=10.
    - Next: ALUWB.
  - ALUWB:
    - Outputs: result_src=00, reg_write=1.
    - Next: FETCH.
  - BEQ:
    - Outputs: a=10, b=00, alu_op=01, result_src=00, pc_write=zero.
    - Next: FETCH.
  - JAL:
    - Outputs: a=01, b=10, alu_op=00, result_src=00, pc_write=1.
    - Next: ALUWB (writes PC+4 to rd).
- Latency with mem_ready tied high, counted in cycles from FETCH entry to the next FETCH:
  - beq: 3
  - R, I-ALU, sw, jal: 4
  - lw: 5
  - Each cycle mem_ready is low in FETCH, MEMREAD or MEMWRITE adds one cycle.
- retire_cnt:
  - Increments by 1 on each transition to FETCH from MEMWB, MEMWRITE, ALUWB or BEQ.
  - Wraps from 2^CNT_W−1 to 0.
  - A skipped opcode does not increment it.
- Reset mid-operation: reset asserted in any state, including MEMWRITE with mem_ready low, returns the FSM to FETCH at that edge. mem_write drops the same cycle and the counter clears.
- op_code must be stable from DECODE until the return to FETCH, because the IR is written only in FETCH.

Optional Feature:
Macro CTRL_ILLEGAL_TRAP_EN.
- Defined:
  - Adds output illegal (1 bit) and a TRAP state.
  - An unknown opcode in DECODE → TRAP.
  - In TRAP, illegal=1, all enables are 0, and the FSM stays there until reset.
  - illegal is 0 in every other state and after reset.
- Undefined: unknown opcodes return to FETCH as described above, and there is no illegal port.

Decomposition:
- Package ctrl_pkg holds:
  - state encoding localparams
  - opcode constants
  - imm_src, alu_src_a/b, result_src and alu_op codes
- One sub-module, imm_sel_dec: combinational op_code→imm_src decoder, reused by the single-cycle top.
- State register, next-state logic, output decode and retire counter stay in multicycle_ctrl_fsm.

Test Plan:
- lw (op 0000011), mem_ready=1 → states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; reg_write=1 with result_src=01 in cycle 5; retire_cnt 0→1.
- sw (op 0100011), mem_ready low for 3 cycles in MEMWRITE → mem_write=1 and adr_src=1 for 4 cycles, imm_src=01 in MEMADR, then FETCH; retire_cnt +1.
- beq, zero=1 → pc_write=1 in cycle 3, imm_src=10 in DECODE; repeat with zero=0 → pc_write=0 in BEQ; both take 3 cycles.
- jal (op 1101111) → pc_write=1 in JAL, then ALUWB with reg_write=1, imm_src=11; 4 cycles.
- op 0000000 → returns to FETCH after DECODE, retire_cnt unchanged; with CTRL_ILLEGAL_TRAP_EN → illegal=1 held until reset.
- CNT_W=4, 16 R-type instructions → retire_cnt wraps to 0; reset during MEMWRITE → next cycle FETCH, mem_write=0, retire_cnt=0.
